// File: rtl/vram_arbiter_pkg.sv
// Shared types and the rotating-priority search used by the VRAM arbiter.
package vram_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int MAX_PORTS = 8;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GRANT_W = grant_w(MAX_PORTS);

  // Returns {valid, index}: first set bit of elig[n-1:0] scanning from (last+1) mod n with wrap.
  function automatic logic [GRANT_W:0] rr_first(input logic [MAX_PORTS-1:0] elig,
                                                input int n, input int last);
    logic [GRANT_W:0]   res;
    logic [GRANT_W-1:0] pos;
    int                 idx;
    res = '0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      if (k <= n && !res[GRANT_W]) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        pos = idx[GRANT_W-1:0];
        if (elig[pos]) res = {1'b1, pos};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester-side and VRAM-side bus of the arbiter; slave is the arbiter's view.
interface vram_arbiter_if #(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            i_request;
  logic [NUM_PORTS-1:0]            i_rw;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] i_wdata;
  logic [DATA_WIDTH-1:0]           o_rdata;
  logic [NUM_PORTS-1:0]            o_ready;
  logic                            o_mem_request;
  logic                            o_mem_rw;
  logic [ADDR_WIDTH-1:0]           o_mem_address;
  logic [DATA_WIDTH-1:0]           o_mem_wdata;
  logic [DATA_WIDTH-1:0]           i_mem_rdata;
  logic                            i_mem_ready;
  logic [GW-1:0]                   o_grant;

  modport slave (
    input  i_request, i_rw, i_address, i_wdata, i_mem_rdata, i_mem_ready,
    output o_rdata, o_ready, o_mem_request, o_mem_rw, o_mem_address, o_mem_wdata, o_grant
  );

  modport master (
    output i_request, i_rw, i_address, i_wdata, i_mem_rdata, i_mem_ready,
    input  o_rdata, o_ready, o_mem_request, o_mem_rw, o_mem_address, o_mem_wdata, o_grant
  );
endinterface

// File: rtl/vram_arbiter_rr_select.sv
// Combinational rotate-priority picker: first eligible index after 'last', with wrap.
module vram_arbiter_rr_select
  import vram_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] index
);
  logic [GRANT_W:0] pick;

  always_comb begin
    pick = rr_first(MAX_PORTS'(eligible), N, int'(last));
  end

  assign valid = pick[GRANT_W];
  assign index = IW'(pick[GRANT_W-1:0]);
endmodule

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: round-robin, one transaction at a time, registered forwarding.
// Build option VRAM_ARBITER_PRIORITY_EN gives port 0 (line fetch) absolute priority.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic           i_clock,
  input  logic           i_reset,
  vram_arbiter_if.slave  bus
);
  localparam int            GW        = grant_w(NUM_PORTS);
  localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

  state_t                 state_q, state_d;
  logic [GW-1:0]          rr_last_q, grant_q;
  logic [NUM_PORTS-1:0]   pending_q, eligible, ready_q;
  logic                   sel_valid, sel_upd_rr;
  logic [GW-1:0]          sel_idx;
  logic                   grant_load, complete;
  logic                   mem_request_q;
  logic                   mem_rw_p1;
  logic [ADDR_WIDTH-1:0]  mem_address_p1;
  logic [DATA_WIDTH-1:0]  mem_wdata_p1;
  logic [DATA_WIDTH-1:0]  rdata_p1;

  // A port that has just been served stays ineligible until it drops its request.
  assign eligible = bus.i_request & ~pending_q;

`ifdef VRAM_ARBITER_PRIORITY_EN
  logic          sub_valid;
  logic [GW-1:0] sub_idx, sub_last;

  // Ports 1..N-1 rotate among themselves; rr_last never holds 0 in this mode.
  assign sub_last = rr_last_q - GW'(1);

  vram_arbiter_rr_select #(.N(NUM_PORTS - 1), .IW(GW)) u_sel (
    .eligible (eligible[NUM_PORTS-1:1]),
    .last     (sub_last),
    .valid    (sub_valid),
    .index    (sub_idx)
  );

  always_comb begin
    sel_valid  = eligible[0] | sub_valid;
    sel_idx    = eligible[0] ? '0 : sub_idx + GW'(1);
    sel_upd_rr = !eligible[0];
  end
`else
  vram_arbiter_rr_select #(.N(NUM_PORTS), .IW(GW)) u_sel (
    .eligible (eligible),
    .last     (rr_last_q),
    .valid    (sel_valid),
    .index    (sel_idx)
  );

  assign sel_upd_rr = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    complete   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_load = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.i_mem_ready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: request fields captured at grant, held until completion.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q        <= IDLE;
      rr_last_q      <= LAST_PORT;
      grant_q        <= '0;
      pending_q      <= '0;
      ready_q        <= '0;
      mem_request_q  <= 1'b0;
      mem_rw_p1      <= 1'b0;
      mem_address_p1 <= '0;
      mem_wdata_p1   <= '0;
      rdata_p1       <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= '0;
      pending_q <= pending_q & bus.i_request;
      if (grant_load) begin
        mem_request_q  <= 1'b1;
        mem_rw_p1      <= bus.i_rw[sel_idx];
        mem_address_p1 <= bus.i_address[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata_p1   <= bus.i_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        grant_q        <= sel_idx;
        if (sel_upd_rr) rr_last_q <= sel_idx;
      end
      if (complete) begin
        mem_request_q      <= 1'b0;
        rdata_p1           <= bus.i_mem_rdata;
        ready_q[grant_q]   <= 1'b1;
        pending_q[grant_q] <= 1'b1;
      end
    end
  end

  assign bus.o_mem_request = mem_request_q;
  assign bus.o_mem_rw      = mem_rw_p1;
  assign bus.o_mem_address = mem_address_p1;
  assign bus.o_mem_wdata   = mem_wdata_p1;
  assign bus.o_rdata       = rdata_p1;
  assign bus.o_ready       = ready_q;
  assign bus.o_grant       = grant_q;
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one VRAM request/ready port between NUM_PORTS requesters, e.g. the video line fetch, CPU window access and a future blitter.
- Arbitration is round-robin, one transaction at a time.
- Address, rw and wdata are forwarded registered; rdata and a single-cycle ready pulse are returned to the granted requester.
- Sits between the video controller's memory ports and the SDRAM/BRAM VRAM controller.

Parameters:
- NUM_PORTS, 3, number of requesters (2..8); port 0 is the video line fetch by convention.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.

Ports:
- i_clock  input  1  system clock.
- i_reset  input  1  synchronous reset, active-high.
- i_request  input  NUM_PORTS  per-port request; held until that port's ready pulse.
- i_rw  input  NUM_PORTS  per-port direction; 1 = write.
- i_address  input  NUM_PORTS*ADDR_WIDTH  packed per-port address; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- i_wdata  input  NUM_PORTS*DATA_WIDTH  packed per-port write data.
- o_rdata  output  DATA_WIDTH  read data, shared; valid with o_ready.
- o_ready  output  NUM_PORTS  one-hot single-cycle completion pulse.
- o_mem_request  output  1  VRAM request.
- o_mem_rw  output  1  VRAM direction.
- o_mem_address  output  ADDR_WIDTH  VRAM address.
- o_mem_wdata  output  DATA_WIDTH  VRAM write data.
- i_mem_rdata  input  DATA_WIDTH  VRAM read data.
- i_mem_ready  input  1  VRAM completion.
- o_grant  output  $clog2(NUM_PORTS)  index of the current or last granted port (debug).

Behaviour:
- Clock and reset: single clock i_clock. Reset is synchronous and active-high on i_reset.
- Reset values: all outputs 0; state IDLE; rr_last = NUM_PORTS-1, so port 0 wins first; all pending_release flags 0.
- Eligibility: port i is eligible when i_request[i]=1 and pending_release[i]=0.
- State IDLE:
  - If any port is eligible, select the first eligible port scanning from (rr_last+1) mod NUM_PORTS upward with wrap.
  - Register that port's rw/address/wdata onto o_mem_*, set o_mem_request=1, set o_grant and rr_last, go to ACCESS.
  - Latency: request sampled at edge N; o_mem_request high after edge N.
- State ACCESS:
  - o_mem_* held stable, including if the requester changes its inputs.
  - On i_mem_ready=1: o_rdata <= i_mem_rdata (for writes too), o_ready[grant] <= 1 for exactly one cycle, o_mem_request <= 0, pending_release[grant] <= 1, go to IDLE.
- Re-grant latency: the earliest next grant is registered on the edge after the ready pulse, giving a minimum of one idle cycle on o_mem_request between transactions.
- pending_release[i]:
  - Cleared on any cycle where i_request[i]=0.
  - Prevents re-granting a requester that has not yet dropped its request after the ready pulse.
  - A requester holding request high after ready is never served twice.
- i_mem_ready while in IDLE: ignored.
- Request withdrawn in ACCESS (protocol violation): the memory transaction still completes; the ready pulse is still issued.
- Simultaneous requests: strict rotation. With all ports continuously requesting and releasing, the grant order is 0,1,2,0,...
- Reset mid-ACCESS: o_mem_request drops on the reset edge; a late i_mem_ready is ignored; no o_ready pulse is issued.
- Single requester: served back-to-back, limited only by its own release cycle.

Optional Feature:
- Macro: VRAM_ARBITER_PRIORITY_EN.
- With the macro defined: in IDLE, an eligible port 0 always wins regardless of rr_last. Ports 1..NUM_PORTS-1 rotate round-robin among themselves, and rr_last is not updated by port 0 grants. This guarantees line-fetch bandwidth during active video.
- Without the macro: pure round-robin across all ports as described above.

Decomposition:
- Package vram_arbiter_pkg holds:
  - state enum (IDLE, ACCESS);
  - a function computing the rotating first-eligible index;
  - localparam GRANT_W = $clog2(NUM_PORTS).
- One sub-module, rr_select: combinational rotate-priority picker taking eligible mask and rr_last, producing valid and index. It is reused for the 1..N-1 subset when VRAM_ARBITER_PRIORITY_EN is defined.

Test Plan:
- Single read: port 1 requests address 0x100; memory returns 0xDEADBEEF after 3 cycles. Expect o_mem_address=0x100 one cycle after request, o_ready=3'b010 for exactly one cycle, o_rdata=0xDEADBEEF.
- Contention: ports 0, 1 and 2 request simultaneously with 1-cycle memory; each drops request after ready and re-requests next cycle. Expect grant order 0,1,2,0,1,2 and never two ready bits set.
- Sticky request: port 2 holds request high for 10 cycles after its ready. Expect exactly one memory transaction and one ready pulse; a new transaction only after request low then high.
- Write forwarding: port 0 writes 0x12345678 to 0x40; its inputs change during ACCESS. Expect o_mem_rw=1, and o_mem_address/o_mem_wdata stay 0x40/0x12345678 until i_mem_ready.
- Reset mid-access: assert i_reset two cycles after grant, then pulse i_mem_ready. Expect o_mem_request=0 after the reset edge, no o_ready, and port 0 granted first afterwards.
- With VRAM_ARBITER_PRIORITY_EN: ports 0 and 1 request continuously, with port 0 re-requesting one cycle after release. Expect port 1 served only in cycles where port 0 is ineligible, and port 0 never skipped.
